twos_complement_serial: RTL and testbench
=========================================

TWOS_COMPLEMENT_SERIAL -- requirements
Module: twos_complement_serial

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 8: operand width in bits; legal values are WIDTH >= 2.
- SIGNED_IN, 1: 1 = operand is two's complement; 0 = operand is unsigned.
REQ-002 Ports SHALL be:
- clk, input, 1: sole clock; all state changes on rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: request a conversion; sampled only in IDLE.
- b, input, WIDTH: operand; captured on the accepted start.
- mode, input, 1: 0 = negate; 1 = absolute value.
- busy, output, 1: conversion in progress.
- done, output, 1: single-cycle pulse; result valid.
- b_prime, output, WIDTH+1: result.
- zero, output, 1: b_prime equals 0; valid with done.
REQ-003 The block SHALL have one clock (clk) and a synchronous, active-low reset (rst_n); there are no other clock or reset inputs.

Function
REQ-004 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 In IDLE with start=1 at an edge, the block SHALL:
- capture b extended to WIDTH+1 bits (sign-extended if SIGNED_IN=1, zero-extended otherwise);
- capture mode;
- clear b_prime and the internal seen_one flag;
- go to SHIFT.
REQ-006 SHIFT SHALL process one bit per cycle, LSB first, for exactly WIDTH+1 cycles, using a 0..WIDTH bit counter.
REQ-007 Per bit x in SHIFT: out = seen_one ? ~x : x, then seen_one <= seen_one | x. out SHALL be shifted in at the MSB of b_prime (shift right), so b_prime is fully assembled after WIDTH+1 cycles.
REQ-008 When mode=1 and the extended operand MSB is 0, each output bit SHALL equal x (pass-through). Abs of a non-negative value is the value itself.
REQ-009 After the last SHIFT bit the FSM SHALL enter DONE. In DONE, done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-010 Latency: if start is accepted at edge k, then busy=1 for cycles k+1 .. k+WIDTH+1 and done=1 in cycle k+WIDTH+2. Total is WIDTH+2 cycles from start to done.
REQ-011 b_prime and zero SHALL hold their value from DONE until the next accepted start.
REQ-012 start while in SHIFT or DONE SHALL be ignored. No queuing; b and mode changes are ignored once captured.
REQ-013 Arithmetic rules:
- The WIDTH+1 result SHALL never overflow. Negating -2^(WIDTH-1) yields +2^(WIDTH-1).
- With SIGNED_IN=0, negation of a nonzero value yields a negative WIDTH+1 value.
- Negating 0 yields 0.
REQ-014 Back-to-back operation: start asserted in the IDLE cycle right after DONE SHALL be accepted. Minimum issue interval is WIDTH+3 cycles.

Reset
REQ-015 With rst_n=0 at an edge, in any state including mid-SHIFT, the block SHALL:
- go to IDLE;
- set busy=0, done=0, b_prime=0, zero=1;
- clear the counter and seen_one.
Any partial result is discarded.
REQ-016 start SHALL be ignored in the cycle rst_n=0; the first acceptable start is at the first edge with rst_n=1.

Configuration
REQ-017 Macro TWOS_COMPLEMENT_ABS_MODE_EN:
- When defined, mode SHALL behave as in REQ-005/REQ-008.
- When undefined, mode SHALL be ignored (treated as 0, always negate), the abs-mode logic SHALL not be synthesised, and the port SHALL remain present.

Verification
REQ-018 WIDTH=3, SIGNED_IN=1, b=3'b011, mode=0, start at edge k -> busy high for 4 cycles; done at k+5; b_prime=4'b1101; zero=0.
REQ-019 WIDTH=3, SIGNED_IN=1, b=3'b100, mode=0 -> b_prime=4'b0100 (+4, no overflow); with SIGNED_IN=0 the same input -> 4'b1100.
REQ-020 WIDTH=8, macro defined, mode=1: b=8'hF6 -> b_prime=9'h00A; b=8'h0A -> 9'h00A. With the macro undefined, b=8'h0A and mode=1 -> 9'h1F6.
REQ-021 WIDTH=8, b=0, mode=0 -> b_prime=0, zero=1, done at k+10.
REQ-022 WIDTH=8: start pulsed again at k+3 with a different b -> ignored; first result unchanged; next start accepted in the IDLE cycle after done.
REQ-023 WIDTH=8: rst_n=0 at k+4 mid-SHIFT -> the next cycle shows busy=0, done=0, b_prime=0, zero=1; no done pulse follows; a new start after reset completes correctly.

Source files
------------

// File: rtl/twos_complement_serial.sv
// Bit-serial two's complement negate / absolute value, LSB first, WIDTH+1 bit result.
// Optional abs mode is enabled by defining TWOS_COMPLEMENT_ABS_MODE_EN.
module twos_complement_serial #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   b_prime,
  output logic             zero
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH:0]  opnd_q, opnd_d;
  logic [WIDTH:0]  res_q, res_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            seen_q, seen_d;
  logic [WIDTH:0]  ext;
  logic            invert;
  logic            out_bit;

  assign ext = SIGNED_IN ? {b[WIDTH-1], b} : {1'b0, b};

`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
  logic mode_q, mode_d;
  // opnd_q shifts with its sign bit replicated, so the MSB stays the operand sign
  assign invert = ~mode_q | opnd_q[WIDTH];
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign invert      = 1'b1;
`endif

  assign out_bit = opnd_q[0] ^ (seen_q & invert);

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          opnd_d  = ext;
          res_d   = '0;
          cnt_d   = '0;
          seen_d  = 1'b0;
`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
          mode_d  = mode;
`endif
          state_d = StShift;
        end
      end
      StShift: begin
        res_d  = {out_bit, res_q[WIDTH:1]};
        opnd_d = {opnd_q[WIDTH], opnd_q[WIDTH:1]};
        seen_d = seen_q | opnd_q[0];
        if (cnt_q == LastBit) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opnd_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign busy    = (state_q == StShift);
  assign done    = (state_q == StDone);
  assign b_prime = res_q;
  assign zero    = (res_q == '0);

endmodule

// File: tb/tb_twos_complement_serial.sv
// Directed bench for twos_complement_serial: 8-bit signed instance plus 3-bit signed/unsigned pair.
module tb_twos_complement_serial;

`ifdef TWOS_COMPLEMENT_ABS_MODE_EN
  localparam bit AbsEn = 1'b1;
`else
  localparam bit AbsEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start8, mode8, busy8, done8, zero8;
  logic [7:0] b8;
  logic [8:0] bp8;
  logic       start3, mode3;
  logic [2:0] b3;
  logic       busy3s, done3s, zero3s, busy3u, done3u, zero3u;
  logic [3:0] bp3s, bp3u;

  int checks   = 0;
  int failures = 0;

  logic [8:0] q8[$];
  logic [3:0] q3s[$];
  logic [3:0] q3u[$];

  twos_complement_serial #(.WIDTH(8), .SIGNED_IN(1'b1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .b(b8), .mode(mode8),
    .busy(busy8), .done(done8), .b_prime(bp8), .zero(zero8)
  );

  twos_complement_serial #(.WIDTH(3), .SIGNED_IN(1'b1)) u3s (
    .clk(clk), .rst_n(rst_n), .start(start3), .b(b3), .mode(mode3),
    .busy(busy3s), .done(done3s), .b_prime(bp3s), .zero(zero3s)
  );

  twos_complement_serial #(.WIDTH(3), .SIGNED_IN(1'b0)) u3u (
    .clk(clk), .rst_n(rst_n), .start(start3), .b(b3), .mode(mode3),
    .busy(busy3u), .done(done3u), .b_prime(bp3u), .zero(zero3u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arithmetic reference: plain negation / abs of the extended operand
  function automatic logic [8:0] model8(input logic [7:0] v, input logic m);
    logic [8:0] e;
    e = {v[7], v};
    if (AbsEn && m && !e[8]) return e;
    return -e;
  endfunction

  function automatic logic [3:0] model3(input logic [2:0] v, input logic sgn);
    logic [3:0] e;
    e = sgn ? {v[2], v} : {1'b0, v};
    return -e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start at the current negedge; glitch>0 re-pulses start (with new b/mode) that cycle.
  task automatic run8(input logic [7:0] v, input logic m, input int glitch);
    logic [8:0] exp;
    int cyc, nbusy;
    bit got;
    q8.push_back(model8(v, m));
    start8 = 1'b1; b8 = v; mode8 = m;
    cyc = 0; nbusy = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      start8 = (cyc == glitch);
      if (cyc == glitch) begin
        b8 = ~v; mode8 = ~m;
      end
      if (busy8) nbusy++;
      if (done8) got = 1'b1;
    end
    exp = q8.pop_front();
    check("u8_done_seen", 32'(got), 32'd1);
    check("u8_latency", cyc, 10);
    check("u8_busy_cycles", nbusy, 9);
    if (got) begin
      check("u8_b_prime", 32'(bp8), 32'(exp));
      check("u8_zero", 32'(zero8), 32'(exp == 9'd0));
      @(negedge clk);
      start8 = 1'b0;
      check("u8_done_pulse", 32'(done8), 32'd0);
      check("u8_idle_busy", 32'(busy8), 32'd0);
      check("u8_hold", 32'(bp8), 32'(exp));
    end
  endtask

  task automatic run3(input logic [2:0] v);
    logic [3:0] es, eu;
    int cyc, nbusy;
    bit got;
    q3s.push_back(model3(v, 1'b1));
    q3u.push_back(model3(v, 1'b0));
    start3 = 1'b1; b3 = v;
    cyc = 0; nbusy = 0; got = 1'b0;
    while (cyc < 20 && !got) begin
      @(negedge clk);
      cyc++;
      start3 = 1'b0;
      if (busy3s) nbusy++;
      if (done3s) got = 1'b1;
    end
    es = q3s.pop_front();
    eu = q3u.pop_front();
    check("u3_done_seen", 32'(got), 32'd1);
    check("u3_latency", cyc, 5);
    check("u3_busy_cycles", nbusy, 4);
    check("u3u_done", 32'(done3u), 32'd1);
    check("u3s_b_prime", 32'(bp3s), 32'(es));
    check("u3s_zero", 32'(zero3s), 32'(es == 4'd0));
    check("u3u_b_prime", 32'(bp3u), 32'(eu));
    check("u3u_zero", 32'(zero3u), 32'(eu == 4'd0));
    @(negedge clk);
    check("u3_done_pulse", 32'(done3s), 32'd0);
  endtask

  initial begin
    int ndone, nbusy;
    rst_n = 1'b0;
    start8 = 1'b1; b8 = 8'h55; mode8 = 1'b0;
    start3 = 1'b1; b3 = 3'd5;  mode3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_b_prime", 32'(bp8), 32'd0);
    check("rst_zero", 32'(zero8), 32'd1);
    check("rst_u3_busy", 32'(busy3s | busy3u), 32'd0);
    check("rst_u3_zero", 32'(zero3s & zero3u), 32'd1);
    start3 = 1'b0;
    rst_n  = 1'b1;

    // First start coincides with the first edge that has rst_n high
    run8(8'h03, 1'b0, 0);
    run8(8'h80, 1'b0, 0);
    run8(8'h00, 1'b0, 0);
    run8(8'h7F, 1'b0, 0);
    run8(8'hF6, 1'b1, 0);
    run8(8'h0A, 1'b1, 0);
    run8(8'h80, 1'b1, 0);
    run8(8'h5A, 1'b0, 3);
    run8(8'hC3, 1'b1, 10);
    for (int i = 0; i < 6; i++) begin
      run8(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset at k+4 in the middle of a conversion
    start8 = 1'b1; b8 = 8'h3C; mode8 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_b_prime", 32'(bp8), 32'd0);
    check("midrst_zero", 32'(zero8), 32'd1);
    rst_n = 1'b1;
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (busy8) nbusy++;
    end
    check("midrst_no_done", ndone, 0);
    check("midrst_no_busy", nbusy, 0);
    run8(8'h3C, 1'b0, 0);

    run3(3'b011);
    run3(3'b100);
    run3(3'b000);
    run3(3'b111);
    run3(3'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
